// File: rtl/bcd_key_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_key_sequencer_if
// Purpose  : Groups the keypad strobe, the ALU operand/result bus and the
//            status/display outputs of the BCD key sequencer.
// Signals  : key_valid/key_code   keypad decoder -> sequencer
//            alu_result           ALU -> sequencer, {sign, tens, ones}
//            op1/op2/opcode/alu_en sequencer -> ALU
//            display/busy/err     sequencer -> display / status
// Modports : master = environment (keypad, ALU, display side)
//            slave  = the sequencer itself
// Revision : 1.0  initial release
// ============================================================================
interface bcd_key_sequencer_if;
  logic       key_valid;
  logic [4:0] key_code;
  logic [8:0] alu_result;
  logic [8:0] op1;
  logic [8:0] op2;
  logic [2:0] opcode;
  logic       alu_en;
  logic [8:0] display;
  logic       busy;
  logic       err;

  modport master (
    output key_valid, key_code, alu_result,
    input  op1, op2, opcode, alu_en, display, busy, err
  );

  modport slave (
    input  key_valid, key_code, alu_result,
    output op1, op2, opcode, alu_en, display, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_key_sequencer
// Purpose  : Operand-entry front end for the BCD ALU. Builds two signed
//            2-digit BCD operands from a keypad stream, holds the ALU enable
//            for EXEC_CYCLES cycles, captures the result, supports chained
//            operations and traps divide-by-zero.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - bcd_key_sequencer_if.slave (keys in, ALU result in,
//                   operands/opcode/alu_en/display/busy/err out)
// Params   : EXEC_CYCLES - cycles alu_en stays high before capture (1..15)
// Revision : 1.0  initial release
// ============================================================================
module bcd_key_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input wire                  clk,
  input wire                  rst,
  bcd_key_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_EXEC    = 3'd2,
    S_SHOW    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam logic [4:0] c_key_add    = 5'd10;
  localparam logic [4:0] c_key_div    = 5'd13;
  localparam logic [4:0] c_key_equals = 5'd14;
  localparam logic [4:0] c_key_clear  = 5'd15;
  localparam logic [4:0] c_key_sign   = 5'd16;
  localparam logic [2:0] c_op_add     = 3'b001;
  localparam logic [2:0] c_op_div     = 3'b100;
  localparam logic [1:0] c_max_digits = 2'd2;
  localparam logic [3:0] c_exec_last  = 4'(EXEC_CYCLES - 1);

  state_t     state_q, state_d;
  logic [8:0] op1_q, op1_d;
  logic [8:0] op2_q, op2_d;
  logic [2:0] opcode_q, opcode_d;
  logic       alu_en_q, alu_en_d;
  logic [8:0] display_q, display_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic [1:0] a_cnt_q, a_cnt_d;
  logic [1:0] b_cnt_q, b_cnt_d;
  logic [3:0] exec_cnt_q, exec_cnt_d;

  // Key classification
  logic       w_is_digit;
  logic       w_is_oper;
  logic       w_is_equals;
  logic       w_is_clear;
  logic       w_is_sign;
  logic [3:0] w_digit;
  logic [4:0] w_oper_off;
  logic [2:0] w_oper_code;

  always_comb begin
    w_is_digit  = bus.key_valid && (bus.key_code < 5'd10);
    w_is_oper   = bus.key_valid && (bus.key_code >= c_key_add) &&
                  (bus.key_code <= c_key_div);
    w_is_equals = bus.key_valid && (bus.key_code == c_key_equals);
    w_is_clear  = bus.key_valid && (bus.key_code == c_key_clear);
    w_is_sign   = bus.key_valid && (bus.key_code == c_key_sign);
    w_digit     = bus.key_code[3:0];
    // Codes 10..13 map onto opcodes 001..100 by subtracting 9.
    w_oper_off  = bus.key_code - 5'd9;
    w_oper_code = w_oper_off[2:0];
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opcode_d   = opcode_q;
    a_cnt_d    = a_cnt_q;
    b_cnt_d    = b_cnt_q;
    exec_cnt_d = exec_cnt_q;
    display_d  = display_q;

    if (w_is_clear) begin
      state_d    = S_ENTER_A;
      op1_d      = 9'd0;
      op2_d      = 9'd0;
      opcode_d   = c_op_add;
      a_cnt_d    = 2'd0;
      b_cnt_d    = 2'd0;
      exec_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_ENTER_A: begin
          if (w_is_digit) begin
            if (a_cnt_q < c_max_digits) begin
              op1_d   = {op1_q[8], op1_q[3:0], w_digit};
              a_cnt_d = a_cnt_q + 2'd1;
            end
          end else if (w_is_oper) begin
            opcode_d = w_oper_code;
            op2_d    = 9'd0;
            b_cnt_d  = 2'd0;
            state_d  = S_ENTER_B;
          end else if (w_is_sign) begin
            op1_d[8] = ~op1_q[8];
          end
        end

        S_ENTER_B: begin
          if (w_is_digit) begin
            if (b_cnt_q < c_max_digits) begin
              op2_d   = {op2_q[8], op2_q[3:0], w_digit};
              b_cnt_d = b_cnt_q + 2'd1;
            end
          end else if (w_is_oper) begin
            // Operator can still be changed until the first B digit arrives.
            if (b_cnt_q == 2'd0) begin
              opcode_d = w_oper_code;
            end
          end else if (w_is_sign) begin
            op2_d[8] = ~op2_q[8];
          end else if (w_is_equals && (b_cnt_q != 2'd0)) begin
            // Magnitude test only: -0 is also a zero divisor.
            if ((opcode_q == c_op_div) && (op2_q[7:0] == 8'd0)) begin
              state_d = S_ERROR;
            end else begin
              state_d    = S_EXEC;
              exec_cnt_d = 4'd0;
            end
          end
        end

        S_EXEC: begin
          if (exec_cnt_q == c_exec_last) begin
            state_d = S_SHOW;
          end else begin
            exec_cnt_d = exec_cnt_q + 4'd1;
          end
        end

        S_SHOW: begin
          if (w_is_oper) begin
            // Chaining: the shown result becomes operand A.
            op1_d    = display_q;
            opcode_d = w_oper_code;
            op2_d    = 9'd0;
            b_cnt_d  = 2'd0;
            state_d  = S_ENTER_B;
          end else if (w_is_digit) begin
            op1_d   = {1'b0, 4'h0, w_digit};
            a_cnt_d = 2'd1;
            op2_d   = 9'd0;
            b_cnt_d = 2'd0;
            state_d = S_ENTER_A;
          end
        end

        S_ERROR: begin
          state_d = S_ERROR;
        end

        default: begin
          state_d = S_ENTER_A;
        end
      endcase
    end

    // Outputs are registered from the next-state values so they change on
    // the same edge as the state and carry no decode glitches.
    case (state_d)
      S_ENTER_A: display_d = op1_d;
      S_ENTER_B: display_d = op2_d;
      S_EXEC:    display_d = op2_d;
      S_SHOW:    display_d = (state_q == S_EXEC) ? bus.alu_result : display_q;
      S_ERROR:   display_d = 9'd0;
      default:   display_d = 9'd0;
    endcase
    alu_en_d = (state_d == S_EXEC);
    busy_d   = (state_d == S_EXEC);
    err_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ENTER_A;
      op1_q      <= 9'd0;
      op2_q      <= 9'd0;
      opcode_q   <= c_op_add;
      alu_en_q   <= 1'b0;
      display_q  <= 9'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      a_cnt_q    <= 2'd0;
      b_cnt_q    <= 2'd0;
      exec_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      opcode_q   <= opcode_d;
      alu_en_q   <= alu_en_d;
      display_q  <= display_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  assign bus.op1     = op1_q;
  assign bus.op2     = op2_q;
  assign bus.opcode  = opcode_q;
  assign bus.alu_en  = alu_en_q;
  assign bus.display = display_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_key_sequencer
// Purpose  : Self-checking bench for bcd_key_sequencer. Two instances
//            (EXEC_CYCLES = 1 and 4) share one key stream; each key strobe
//            can be masked per instance. Expected ALU transactions are queued
//            by the stimulus and checked by a monitor on every alu_en burst.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_key_sequencer;

  typedef struct packed {
    logic [8:0] op1;
    logic [8:0] op2;
    logic [2:0] opc;
    logic [8:0] res;
    logic [8:0] cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kv = 1'b0;
  logic [4:0] kc = 5'd0;
  logic [8:0] ares = 9'h059;
  logic [1:0] mask = 2'b11;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  bcd_key_sequencer_if if1 ();
  bcd_key_sequencer_if if4 ();

  assign if1.key_valid  = kv & mask[0];
  assign if1.key_code   = kc;
  assign if1.alu_result = ares;
  assign if4.key_valid  = kv & mask[1];
  assign if4.key_code   = kc;
  assign if4.alu_result = ares;

  bcd_key_sequencer #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bcd_key_sequencer #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic [1:0] m_en, m_busy, m_err;
  logic [8:0] m_op1 [2];
  logic [8:0] m_op2 [2];
  logic [8:0] m_disp [2];
  logic [2:0] m_opc [2];

  assign m_en   = {if4.alu_en, if1.alu_en};
  assign m_busy = {if4.busy, if1.busy};
  assign m_err  = {if4.err, if1.err};
  assign m_op1[0] = if1.op1;      assign m_op1[1] = if4.op1;
  assign m_op2[0] = if1.op2;      assign m_op2[1] = if4.op2;
  assign m_disp[0] = if1.display; assign m_disp[1] = if4.display;
  assign m_opc[0] = if1.opcode;   assign m_opc[1] = if4.opcode;

  task automatic chk(input string nm, input int d, input logic [8:0] act,
                     input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (ec%0d): got %h expected %h", nm, (d == 0) ? 1 : 4, act, exp);
    end
  endtask

  // Checks every visible output of each unmasked instance.
  task automatic chk_state(input string nm, input logic [8:0] op1,
                           input logic [8:0] op2, input logic [2:0] opc,
                           input logic [8:0] disp, input logic err,
                           input logic busy);
    for (int d = 0; d < 2; d++) begin
      if (mask[d]) begin
        chk({nm, ".op1"}, d, m_op1[d], op1);
        chk({nm, ".op2"}, d, m_op2[d], op2);
        chk({nm, ".opcode"}, d, {6'd0, m_opc[d]}, {6'd0, opc});
        chk({nm, ".display"}, d, m_disp[d], disp);
        chk({nm, ".err"}, d, {8'd0, m_err[d]}, {8'd0, err});
        chk({nm, ".busy"}, d, {8'd0, m_busy[d]}, {8'd0, busy});
      end
    end
  endtask

  task automatic press(input logic [4:0] code);
    @(posedge clk);
    #1;
    kv = 1'b1;
    kc = code;
    @(posedge clk);
    #1;
    kv = 1'b0;
  endtask

  task automatic push(input logic [8:0] op1, input logic [8:0] op2,
                      input logic [2:0] opc, input logic [8:0] res);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.opc = opc; e.res = res;
    if (mask[0]) begin
      e.cycles = 9'd1;
      q1.push_back(e);
    end
    if (mask[1]) begin
      e.cycles = 9'd4;
      q4.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected transaction per alu_en burst.
  logic [1:0] en_prev = 2'b00;
  logic [1:0] active  = 2'b00;
  int         run [2];
  exp_t       cur [2];

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          en_prev[d] = 1'b0;
          active[d]  = 1'b0;
        end else begin
          if (m_en[d] && !en_prev[d]) begin
            if ((d == 0 && q1.size() == 0) || (d == 1 && q4.size() == 0)) begin
              chk("alu_en_unexpected", d, {8'd0, m_en[d]}, 9'd0);
              active[d] = 1'b0;
            end else begin
              if (d == 0) cur[d] = q1.pop_front();
              else        cur[d] = q4.pop_front();
              active[d] = 1'b1;
              run[d]    = 0;
            end
          end
          if (m_en[d] && active[d]) begin
            run[d]++;
            chk("exec.busy", d, {8'd0, m_busy[d]}, 9'd1);
            chk("exec.op1", d, m_op1[d], cur[d].op1);
            chk("exec.op2", d, m_op2[d], cur[d].op2);
            chk("exec.opcode", d, {6'd0, m_opc[d]}, {6'd0, cur[d].opc});
          end
          if (!m_en[d] && en_prev[d] && active[d]) begin
            chk("exec.cycles", d, 9'(run[d]), cur[d].cycles);
            chk("exec.result", d, m_disp[d], cur[d].res);
            chk("exec.busy_after", d, {8'd0, m_busy[d]}, 9'd0);
            active[d] = 1'b0;
          end
          en_prev[d] = m_en[d];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk_state("reset", 9'h000, 9'h000, 3'b001, 9'h000, 1'b0, 1'b0);

    // Basic add: 42 + 17, ALU returns 059
    press(5'd4);  chk_state("a4",  9'h004, 9'h000, 3'b001, 9'h004, 1'b0, 1'b0);
    press(5'd2);  chk_state("a42", 9'h042, 9'h000, 3'b001, 9'h042, 1'b0, 1'b0);
    press(5'd10); chk_state("add", 9'h042, 9'h000, 3'b001, 9'h000, 1'b0, 1'b0);
    press(5'd1);  chk_state("b1",  9'h042, 9'h001, 3'b001, 9'h001, 1'b0, 1'b0);
    press(5'd7);  chk_state("b17", 9'h042, 9'h017, 3'b001, 9'h017, 1'b0, 1'b0);
    push(9'h042, 9'h017, 3'b001, 9'h059);
    press(5'd14);
    idle(6);      chk_state("show1", 9'h042, 9'h017, 3'b001, 9'h059, 1'b0, 1'b0);
    press(5'd14); press(5'd16); press(5'd17); press(5'd31);
    chk_state("show_ign", 9'h042, 9'h017, 3'b001, 9'h059, 1'b0, 1'b0);

    // Digit after result starts a new operand A; third digit dropped
    press(5'd1);  chk_state("n1",   9'h001, 9'h000, 3'b001, 9'h001, 1'b0, 1'b0);
    press(5'd2);  chk_state("n12",  9'h012, 9'h000, 3'b001, 9'h012, 1'b0, 1'b0);
    press(5'd3);  chk_state("n123", 9'h012, 9'h000, 3'b001, 9'h012, 1'b0, 1'b0);
    press(5'd16); chk_state("neg",  9'h112, 9'h000, 3'b001, 9'h112, 1'b0, 1'b0);
    press(5'd17); press(5'd31); press(5'd14);
    @(posedge clk); #1; kc = 5'd3; idle(2);
    chk_state("a_ign", 9'h112, 9'h000, 3'b001, 9'h112, 1'b0, 1'b0);
    press(5'd15); chk_state("clr1", 9'h000, 9'h000, 3'b001, 9'h000, 1'b0, 1'b0);

    // Divide by zero
    press(5'd5); press(5'd13);
    chk_state("div", 9'h005, 9'h000, 3'b100, 9'h000, 1'b0, 1'b0);
    press(5'd14); chk_state("eq_nob", 9'h005, 9'h000, 3'b100, 9'h000, 1'b0, 1'b0);
    press(5'd0);  press(5'd14);
    chk_state("err", 9'h005, 9'h000, 3'b100, 9'h000, 1'b1, 1'b0);
    press(5'd7); press(5'd14); press(5'd17); press(5'd16);
    chk_state("err_ign", 9'h005, 9'h000, 3'b100, 9'h000, 1'b1, 1'b0);
    press(5'd15); chk_state("clr2", 9'h000, 9'h000, 3'b001, 9'h000, 1'b0, 1'b0);

    // Chaining: 3*4 = 012, then - 2 = with operator re-selection
    ares = 9'h012;
    press(5'd3); press(5'd12); press(5'd4);
    push(9'h003, 9'h004, 3'b011, 9'h012);
    press(5'd14);
    idle(6);     chk_state("show2", 9'h003, 9'h004, 3'b011, 9'h012, 1'b0, 1'b0);
    press(5'd11); chk_state("chain", 9'h012, 9'h000, 3'b010, 9'h000, 1'b0, 1'b0);
    press(5'd10); chk_state("repl",  9'h012, 9'h000, 3'b001, 9'h000, 1'b0, 1'b0);
    press(5'd11); press(5'd2); press(5'd10);
    chk_state("op_lock", 9'h012, 9'h002, 3'b010, 9'h002, 1'b0, 1'b0);
    ares = 9'h010;
    push(9'h012, 9'h002, 3'b010, 9'h010);
    press(5'd14);
    idle(6);     chk_state("show3", 9'h012, 9'h002, 3'b010, 9'h010, 1'b0, 1'b0);
    press(5'd15);

    // Long EXEC on the 4-cycle instance only
    mask = 2'b10;
    ares = 9'h123;
    press(5'd6); press(5'd10); press(5'd3);
    push(9'h006, 9'h003, 3'b001, 9'h123);
    press(5'd14);
    press(5'd9);  chk_state("exec_drop", 9'h006, 9'h003, 3'b001, 9'h003, 1'b0, 1'b1);
    idle(6);      chk_state("show4", 9'h006, 9'h003, 3'b001, 9'h123, 1'b0, 1'b0);
    press(5'd11); press(5'd5);
    push(9'h123, 9'h005, 3'b010, 9'h000);
    press(5'd14);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_alu_en", 1, {8'd0, if4.alu_en}, 9'd0);
    chk_state("rst_exec", 9'h000, 9'h000, 3'b001, 9'h000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    mask = 2'b11;
    idle(2);
    chk_state("final", 9'h000, 9'h000, 3'b001, 9'h000, 1'b0, 1'b0);
    chk("q1_left", 0, 9'(q1.size()), 9'd0);
    chk("q4_left", 1, 9'(q4.size()), 9'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
